serial_send_mlane: RTL
======================

Name: serial_send_mlane

Overview:
- Parametrised multi-lane parallel-to-serial sender for the BER link; a single clock replaces the fast/slow dual-clock scheme.
- Accepts WORD_W-bit words over a valid/ready handshake and splits each word across LANES lanes.
- Each lane shifts out 2 bits per CLK as a D0/D1 pair for an external per-lane DDR output cell.
- Transmits a fixed idle pattern when no data is available and counts underruns.

Parameters:
- WORD_W, 64, word width; must be divisible by 2*LANES.
- LANES, 2, number of serial lanes.
- IDLE_PAT, 2'b10, {D0,D1} driven on every lane while idle.
- CNT_W, 16, underrun counter width.

Ports:
- CLK  in  1  sole clock.
- RSTX  in  1  asynchronous active-low reset.
- DIN  in  WORD_W  parallel word.
- DIN_VLD  in  1  DIN valid.
- DIN_RDY  out  1  block accepts DIN this cycle.
- DOUT_D0  out  LANES  per-lane first-half-cycle bit (DDR rising edge).
- DOUT_D1  out  LANES  per-lane second-half-cycle bit (DDR falling edge).
- FRM  out  1  high on the first beat of each transmitted word.
- CNT_CLR  in  1  synchronous clear of UNDERRUN_CNT.
- UNDERRUN_CNT  out  CNT_W  saturating underrun count.

Behaviour:
- Definitions:
  - LW = WORD_W/LANES bits per lane.
  - N = LW/2 beats per word (default 16).
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RSTX.
- Reset values:
  - State IDLE, beat counter 0, shift registers 0.
  - DOUT_D0/D1 = 0, FRM = 0, UNDERRUN_CNT = 0.
  - DIN_RDY = 0 while RSTX is low and through the first CLK edge after release (registered enable); normal behaviour from then on.
- Lane mapping:
  - Lane k takes DIN[WORD_W-1-k*LW -: LW], MSB first.
  - Each beat: D0 = lane shift[LW-1], D1 = shift[LW-2]; then shift left by 2, zero fill.
- Handshake:
  - DIN_RDY = en & (state==IDLE | beat==N-1), combinational.
  - A transfer occurs when DIN_VLD & DIN_RDY.
  - DIN may change freely when no transfer occurs.
- Latency: a word accepted at edge t appears on DOUT after edge t, with FRM=1 for that beat. All outputs are registered.
- State IDLE:
  - DOUT = IDLE_PAT on all lanes, FRM = 0.
  - A transfer loads the shift registers, sets beat = 0, goes to SEND.
- State SEND:
  - Beat increments each CLK.
  - At beat N-1 with a transfer: reload and set beat = 0. Back-to-back words have no gap.
  - At beat N-1 without a transfer: go to IDLE and increment UNDERRUN_CNT once. Further idle cycles do not increment it.
- UNDERRUN_CNT:
  - Saturates at all-ones.
  - CNT_CLR wins over a simultaneous increment (result 0).
- Reset mid-word: outputs go to 0 immediately (asynchronous) and the partial word is discarded.

Optional Feature:
- Macro: SERIAL_SEND_PRBS_EN.
- Defined:
  - Adds input PRBS_MODE (1 bit).
  - When PRBS_MODE=1, the word source is PRBS-7 (x^7+x^6+1), seeded 7'h7F at reset, advanced WORD_W bits per word.
  - In PRBS mode: DIN is ignored, DIN_RDY = 0, the block never underruns (a new word every N beats), UNDERRUN_CNT holds.
  - PRBS_MODE is sampled only at word boundaries or in IDLE.
- Undefined: the PRBS_MODE port and all PRBS logic are absent.

Decomposition:
- Package serial_send_pkg:
  - State enum {IDLE, SEND}.
  - PRBS7 tap and seed constants.
  - Function prbs7_next(seed, nbits) returning the next word and seed.
- Sub-module serial_send_prbs: PRBS word generator with an advance strobe, instantiated only under SERIAL_SEND_PRBS_EN.

Test Plan:
- Reset release, no VLD:
  - DIN_RDY=0 on the first edge, then 1.
  - DOUT_D0=1, D1=0 on both lanes; UNDERRUN_CNT=0.
- Single word DIN=64'hF0E1D2C3B4A59687, defaults:
  - Next cycle FRM=1; lane0 {D0,D1}=2'b11, lane1=2'b10.
  - After 16 beats returns to idle; UNDERRUN_CNT=1.
- VLD held high with 3 words:
  - Accepted at beats 15; FRM every 16 cycles.
  - No idle beats between words; UNDERRUN_CNT=0.
- CNT_CLR on the same cycle as an underrun, with CNT at 5 -> CNT reads 0.
- CNT at all-ones plus a further underrun -> stays all-ones.
- RSTX pulled low at beat 7 -> outputs 0 asynchronously; after release the block resumes idle pattern.
- SERIAL_SEND_PRBS_EN with PRBS_MODE=1 -> lane0/lane1 bitstream matches the PRBS7 reference model from seed 7'h7F; DIN_RDY=0.

Source files
------------

// File: rtl/serial_send_pkg.sv
// Shared state encoding and PRBS-7 word generation for the multi-lane serial sender.
package serial_send_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    // Polynomial x^7 + x^6 + 1: feedback is bit6 ^ bit5.
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam int         PRBS_MAX_W = 256;

    typedef struct packed {
        logic [PRBS_MAX_W-1:0] word;
        logic [6:0]            seed;
    } prbs7_res_t;

    // Generated bits land MSB first in the low nbits of the returned word.
    function automatic prbs7_res_t prbs7_next(input logic [6:0] seed, input int nbits);
        prbs7_res_t res;
        logic [6:0] s;
        logic       b;
        s        = seed;
        b        = 1'b0;
        res.word = '0;
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < nbits) begin
                b        = ^(s & PRBS7_TAPS);
                s        = {s[5:0], b};
                res.word = {res.word[PRBS_MAX_W-2:0], b};
            end
        end
        res.seed = s;
        return res;
    endfunction

endpackage

// File: rtl/serial_send_prbs.sv
// PRBS-7 word source; the seed steps WORD_W bits on each advance strobe.
module serial_send_prbs
    import serial_send_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              advance,
    output logic [WORD_W-1:0] word
);

    prbs7_res_t nxt;
    logic [6:0] seed;

    always_comb nxt = prbs7_next(seed, WORD_W);

    assign word = nxt.word[WORD_W-1:0];

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            seed <= PRBS7_SEED;
        end else if (advance) begin
            seed <= nxt.seed;
        end
    end

endmodule

// File: rtl/serial_send_mlane.sv
// Multi-lane word-to-DDR-pair serialiser with idle fill and underrun counting.
// Optional PRBS-7 word source is compiled in with SERIAL_SEND_PRBS_EN.
//
//   state | meaning
//   IDLE  | no word in flight, lanes drive IDLE_PAT, ready for a word
//   SEND  | shifting a word out, beat counts 0..N-1
module serial_send_mlane
    import serial_send_pkg::*;
#(
    parameter int         WORD_W   = 64,
    parameter int         LANES    = 2,
    parameter logic [1:0] IDLE_PAT = 2'b10,
    parameter int         CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic [WORD_W-1:0] DIN,
    input  logic              DIN_VLD,
    output logic              DIN_RDY,
    output logic [LANES-1:0]  DOUT_D0,
    output logic [LANES-1:0]  DOUT_D1,
    output logic              FRM,
    input  logic              CNT_CLR,
`ifdef SERIAL_SEND_PRBS_EN
    input  logic              PRBS_MODE,
`endif
    output logic [CNT_W-1:0]  UNDERRUN_CNT
);

    localparam int            LW   = WORD_W / LANES;
    localparam int            N    = LW / 2;
    localparam int            BW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST = BW'(N - 1);

    state_t            state, state_nx;
    logic [BW-1:0]     beat, beat_nx;
    logic [LW-1:0]     shift    [LANES];
    logic [LW-1:0]     shift_nx [LANES];
    logic [LANES-1:0]  d0_nx, d1_nx;
    logic              frm_nx;
    logic              en;
    logic              boundary, load, underrun;
    logic [WORD_W-1:0] src_word;

    assign boundary = (state == IDLE) || (beat == LAST);

`ifdef SERIAL_SEND_PRBS_EN
    logic [WORD_W-1:0] prbs_word;
    logic              prbs_load;

    // The PRBS source only takes over at a word boundary, so a word is never split.
    assign prbs_load = en && boundary && PRBS_MODE;
    assign DIN_RDY   = en && boundary && !PRBS_MODE;
    assign load      = (DIN_VLD && DIN_RDY) || prbs_load;
    assign src_word  = PRBS_MODE ? prbs_word : DIN;

    serial_send_prbs #(.WORD_W(WORD_W)) u_prbs (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .advance (prbs_load),
        .word    (prbs_word)
    );
`else
    assign DIN_RDY  = en && boundary;
    assign load     = DIN_VLD && DIN_RDY;
    assign src_word = DIN;
`endif

    assign underrun = (state == SEND) && (beat == LAST) && !load;

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        frm_nx   = 1'b0;
        d0_nx    = {LANES{IDLE_PAT[1]}};
        d1_nx    = {LANES{IDLE_PAT[0]}};
        for (int k = 0; k < LANES; k++) begin
            shift_nx[k] = shift[k];
        end

        if (load) begin
            // First beat goes straight from the source word to the outputs.
            state_nx = SEND;
            beat_nx  = '0;
            frm_nx   = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                d0_nx[k]    = src_word[WORD_W-1-k*LW];
                d1_nx[k]    = src_word[WORD_W-2-k*LW];
                shift_nx[k] = src_word[WORD_W-1-k*LW -: LW] << 2;
            end
        end else if ((state == SEND) && (beat != LAST)) begin
            beat_nx = beat + BW'(1);
            for (int k = 0; k < LANES; k++) begin
                d0_nx[k]    = shift[k][LW-1];
                d1_nx[k]    = shift[k][LW-2];
                shift_nx[k] = shift[k] << 2;
            end
        end else begin
            state_nx = IDLE;
            beat_nx  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            en           <= 1'b0;
            state        <= IDLE;
            beat         <= '0;
            DOUT_D0      <= '0;
            DOUT_D1      <= '0;
            FRM          <= 1'b0;
            UNDERRUN_CNT <= '0;
            for (int k = 0; k < LANES; k++) begin
                shift[k] <= '0;
            end
        end else begin
            en      <= 1'b1;
            state   <= state_nx;
            beat    <= beat_nx;
            DOUT_D0 <= d0_nx;
            DOUT_D1 <= d1_nx;
            FRM     <= frm_nx;
            for (int k = 0; k < LANES; k++) begin
                shift[k] <= shift_nx[k];
            end
            if (CNT_CLR) begin
                UNDERRUN_CNT <= '0;
            end else if (underrun && (UNDERRUN_CNT != '1)) begin
                UNDERRUN_CNT <= UNDERRUN_CNT + CNT_W'(1);
            end
        end
    end

endmodule
